// File: rtl/iot_pkg.sv
// rtl/iot_pkg.sv - shared IOT device constants, width-sized typedef macros and status struct
`ifndef IOT_PKG_SV
`define IOT_PKG_SV

`define IOT_WORD_T(W) logic [(W)-1:0]
`define IOT_PTR_T(D)  logic [$clog2(D)-1:0]
`define IOT_CNT_T(D)  logic [$clog2(D):0]

package iot_pkg;
  localparam int unsigned IOT_DEF_WIDTH = 8;
  localparam int unsigned IOT_DEF_DEPTH = 4;

  typedef struct packed {
    logic ready;
    logic tx_ready;
    logic err;
  } iot_status_t;
endpackage

`endif

// File: rtl/iot_sync_fifo.sv
// rtl/iot_sync_fifo.sv - single-clock FIFO, power-of-two depth, head reads as 0 when empty
module iot_sync_fifo
  import iot_pkg::*;
#(
  parameter int unsigned WIDTH = IOT_DEF_WIDTH,
  parameter int unsigned DEPTH = IOT_DEF_DEPTH
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               push,
  input  logic               pop,
  input  `IOT_WORD_T(WIDTH)  wdata,
  output `IOT_WORD_T(WIDTH)  rdata,
  output logic               empty,
  output logic               full,
  output `IOT_CNT_T(DEPTH)   count
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam `IOT_CNT_T(DEPTH) FULL_CNT = (PW+1)'(DEPTH);

  `IOT_WORD_T(WIDTH) mem_q [DEPTH];
  `IOT_PTR_T(DEPTH)  wr_q, wr_d, rd_q, rd_d;
  `IOT_CNT_T(DEPTH)  cnt_q, cnt_d;

  // Pointers wrap modulo DEPTH through natural overflow of the PW-bit counters.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push) wr_d = wr_q + 1'b1;
    if (pop)  rd_d = rd_q + 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= wdata;
  end

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == FULL_CNT);
  assign count = cnt_q;
  assign rdata = empty ? '0 : mem_q[rd_q];
endmodule

// File: rtl/iot_buffered_port.sv
// rtl/iot_buffered_port.sv - PDP-8 IOT port with TX/RX FIFOs; IOT_IRQ_EN adds ie_set/ie_clr/irq
// Every output comes from a register or FIFO state, never straight from an input.
module iot_buffered_port
  import iot_pkg::*;
#(
  parameter int unsigned WIDTH            = IOT_DEF_WIDTH,
  parameter int unsigned DEPTH            = IOT_DEF_DEPTH,
  parameter bit          CLEARACC_ON_READ = 1'b1
) (
  input  logic             clk,
  input  logic             nrst,
`ifdef IOT_IRQ_EN
  input  logic             ie_set,
  input  logic             ie_clr,
  output logic             irq,
`endif
  input  logic             iot_load,
  input  logic [WIDTH-1:0] iot_dataout,
  input  logic             iot_clear,
  input  logic             iot_clear_err,
  output logic             iot_ready,
  output logic             iot_tx_ready,
  output logic [WIDTH-1:0] iot_datain,
  output logic             iot_clearacc,
  output logic             iot_err,
  output logic             tx_valid,
  output logic [WIDTH-1:0] tx_data,
  input  logic             tx_accept,
  input  logic             rx_strobe,
  input  logic [WIDTH-1:0] rx_data
);
  logic tx_push, tx_pop, tx_empty, tx_full;
  logic rx_push, rx_pop, rx_empty, rx_full;
  `IOT_CNT_T(DEPTH) tx_cnt, rx_cnt;
  logic err_q, err_d, err_set;
  logic clearacc_q, clearacc_d;
  iot_status_t status;
  logic unused_cnt;

  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign tx_pop  = !tx_empty && tx_accept;
  assign tx_push = iot_load && (!tx_full || tx_pop);
  assign rx_pop  = iot_clear && !rx_empty;
  assign rx_push = rx_strobe && (!rx_full || rx_pop);
  assign err_set = (iot_load && tx_full && !tx_pop) || (rx_strobe && rx_full && !rx_pop);

  iot_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_tx_fifo (
    .clk(clk), .nrst(nrst), .push(tx_push), .pop(tx_pop), .wdata(iot_dataout),
    .rdata(tx_data), .empty(tx_empty), .full(tx_full), .count(tx_cnt)
  );

  iot_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rx_fifo (
    .clk(clk), .nrst(nrst), .push(rx_push), .pop(rx_pop), .wdata(rx_data),
    .rdata(iot_datain), .empty(rx_empty), .full(rx_full), .count(rx_cnt)
  );

  always_comb begin
    err_d = err_q;
    if (err_set)            err_d = 1'b1;
    else if (iot_clear_err) err_d = 1'b0;
    clearacc_d = CLEARACC_ON_READ ? rx_pop : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      err_q      <= 1'b0;
      clearacc_q <= 1'b0;
    end else begin
      err_q      <= err_d;
      clearacc_q <= clearacc_d;
    end
  end

`ifdef IOT_IRQ_EN
  logic ie_q, ie_d, irq_q, irq_d;

  always_comb begin
    ie_d = ie_q;
    if (ie_set)      ie_d = 1'b1;
    else if (ie_clr) ie_d = 1'b0;
    irq_d = ie_d && (!rx_empty || tx_empty);
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      ie_q  <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      ie_q  <= ie_d;
      irq_q <= irq_d;
    end
  end

  assign irq = irq_q;
`endif

  assign status       = '{ready: !rx_empty, tx_ready: !tx_full, err: err_q};
  assign iot_ready    = status.ready;
  assign iot_tx_ready = status.tx_ready;
  assign iot_err      = status.err;
  assign iot_clearacc = clearacc_q;
  assign tx_valid     = !tx_empty;
  assign unused_cnt   = ^{tx_cnt, rx_cnt};
endmodule

// File: tb/tb_iot_buffered_port.sv
// tb/tb_iot_buffered_port.sv - scoreboard bench for iot_buffered_port (irq checks when IOT_IRQ_EN)
module tb_iot_buffered_port;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       nrst;
  logic       iot_load, iot_clear, iot_clear_err, tx_accept, rx_strobe;
  logic [7:0] iot_dataout, rx_data;
  logic       iot_ready, iot_tx_ready, iot_clearacc, iot_err, tx_valid;
  logic [7:0] iot_datain, tx_data;
`ifdef IOT_IRQ_EN
  logic       ie_set, ie_clr, irq;
`endif

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] rx_sb[$];
  logic [7:0] tx_sb[$];
  logic       exp_err;

  always #5 clk = ~clk;

  iot_buffered_port #(.WIDTH(8), .DEPTH(D), .CLEARACC_ON_READ(1'b1)) dut (
    .clk(clk), .nrst(nrst),
`ifdef IOT_IRQ_EN
    .ie_set(ie_set), .ie_clr(ie_clr), .irq(irq),
`endif
    .iot_load(iot_load), .iot_dataout(iot_dataout), .iot_clear(iot_clear),
    .iot_clear_err(iot_clear_err), .iot_ready(iot_ready), .iot_tx_ready(iot_tx_ready),
    .iot_datain(iot_datain), .iot_clearacc(iot_clearacc), .iot_err(iot_err),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_accept(tx_accept),
    .rx_strobe(rx_strobe), .rx_data(rx_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    iot_load = 0; iot_dataout = 0; iot_clear = 0; iot_clear_err = 0;
    tx_accept = 0; rx_strobe = 0; rx_data = 0;
  endtask

  task automatic check_flags(input logic exp_clearacc);
    check("iot_ready", 32'(iot_ready), 32'(rx_sb.size() != 0));
    check("iot_tx_ready", 32'(iot_tx_ready), 32'(tx_sb.size() < D));
    check("tx_valid", 32'(tx_valid), 32'(tx_sb.size() != 0));
    check("iot_err", 32'(iot_err), 32'(exp_err));
    check("iot_clearacc", 32'(iot_clearacc), 32'(exp_clearacc));
    if (rx_sb.size() == 0) check("datain_empty", 32'(iot_datain), 32'd0);
    if (tx_sb.size() == 0) check("txdata_empty", 32'(tx_data), 32'd0);
  endtask

  // One clock of stimulus; heads are compared before the edge that pops them.
  task automatic cycle(input logic ld, input logic [7:0] dout, input logic clr, input logic clre,
                       input logic acc, input logic stb, input logic [7:0] rd);
    logic rx_pop, tx_pop, set;
    iot_load = ld; iot_dataout = dout; iot_clear = clr; iot_clear_err = clre;
    tx_accept = acc; rx_strobe = stb; rx_data = rd;
    rx_pop = clr && (rx_sb.size() > 0);
    tx_pop = acc && (tx_sb.size() > 0);
    set = 0;
    if (rx_pop) check("rx_head", 32'(iot_datain), 32'(rx_sb.pop_front()));
    if (tx_pop) check("tx_head", 32'(tx_data), 32'(tx_sb.pop_front()));
    if (stb) begin
      if (rx_sb.size() < D) rx_sb.push_back(rd);
      else set = 1;
    end
    if (ld) begin
      if (tx_sb.size() < D) tx_sb.push_back(dout);
      else set = 1;
    end
    if (set) exp_err = 1;
    else if (clre) exp_err = 0;
    @(posedge clk); #1;
    idle_inputs();
    check_flags(rx_pop);
  endtask

  task automatic do_reset();
    nrst = 0;
    for (int i = 0; i < 2; i++) begin
      iot_load = 1'($urandom); iot_dataout = 8'($urandom); iot_clear = 1'($urandom);
      iot_clear_err = 1'($urandom); tx_accept = 1'($urandom); rx_strobe = 1'($urandom);
      rx_data = 8'($urandom);
`ifdef IOT_IRQ_EN
      ie_set = 1'($urandom); ie_clr = 1'($urandom);
`endif
      @(posedge clk); #1;
    end
    idle_inputs();
`ifdef IOT_IRQ_EN
    ie_set = 0; ie_clr = 0;
`endif
    nrst = 1;
    rx_sb.delete(); tx_sb.delete(); exp_err = 0;
    check_flags(1'b0);
`ifdef IOT_IRQ_EN
    check("irq_reset", 32'(irq), 32'd0);
`endif
  endtask

  initial begin
    idle_inputs();
    nrst = 0;
    exp_err = 0;
`ifdef IOT_IRQ_EN
    ie_set = 0; ie_clr = 0;
`endif
    do_reset();

    // RX ordering with clearacc pulses
    cycle(0, 0, 0, 0, 0, 1, 8'h41);
    cycle(0, 0, 0, 0, 0, 1, 8'h42);
    cycle(0, 0, 1, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 0, 0);

    // RX overflow; error set beats clear in the same cycle
    for (int i = 1; i <= 5; i++) cycle(0, 0, 0, 0, 0, 1, 8'(i));
    cycle(0, 0, 0, 1, 0, 1, 8'h06);
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0, 0);

    // Strobe while full but with a pop in the same cycle is accepted
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 1, 8'(8'h20 + i));
    cycle(0, 0, 1, 0, 0, 1, 8'h24);
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0, 0, 0, 0);

    // TX full, then load with simultaneous accept keeps it full and error-free
    for (int i = 0; i < 4; i++) cycle(1, 8'(8'h10 + i), 0, 0, 0, 0, 0);
    cycle(1, 8'h7F, 0, 0, 1, 0, 0);
    cycle(1, 8'h55, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 1, 0, 0);

    // Wrap-around on both FIFOs
    for (int i = 0; i < 10; i++) begin
      cycle(1, 8'($urandom), 0, 0, 0, 1, 8'($urandom));
      cycle(0, 0, 1, 0, 1, 0, 0);
    end

    // Reset mid-transfer discards buffered data
    cycle(1, 8'hAA, 0, 0, 0, 1, 8'hBB);
    cycle(1, 8'hCC, 0, 0, 0, 1, 8'hDD);
    do_reset();

`ifdef IOT_IRQ_EN
    cycle(1, 8'h10, 0, 0, 0, 0, 0);
    ie_set = 1;
    @(posedge clk); #1;
    ie_set = 0;
    check("irq_tx_busy", 32'(irq), 32'd0);
    cycle(0, 0, 0, 0, 0, 1, 8'h33);
    check("irq_one_after", 32'(irq), 32'd0);
    @(posedge clk); #1;
    check("irq_two_after", 32'(irq), 32'd1);
    ie_clr = 1;
    @(posedge clk); #1;
    ie_clr = 0;
    check("irq_ie_clr", 32'(irq), 32'd0);
    cycle(0, 0, 1, 0, 1, 0, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
